// File: rtl/stack_sequencer.sv
// stack_sequencer: turns calculator stack ops into per-cycle commands for a
// word stack built from WIDTH shift_register bit-planes. It tracks the number
// of valid entries and refuses ops that would overflow or underflow the stack.
// Command encodings mirror the STACK_MODE_* values the planes decode.

module stack_sequencer #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  input  logic [WIDTH-1:0] stk_top0,
  input  logic [WIDTH-1:0] stk_top1,
  output logic [2:0]       stk_mode,
  output logic [WIDTH-1:0] stk_d,
  output logic [DW-1:0]    depth,
  output logic             err_ovf,
  output logic             err_udf
);

  // Plane command encodings
  localparam logic [2:0] STACK_MODE_IDLE  = 3'd0;
  localparam logic [2:0] STACK_MODE_PUSH  = 3'd1;
  localparam logic [2:0] STACK_MODE_POP   = 3'd2;
  localparam logic [2:0] STACK_MODE_SWAP  = 3'd3;
  localparam logic [2:0] STACK_MODE_RESET = 3'd4;

  // Op encodings from the decoder
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_SWAP  = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_ADD   = 3'd5;
  localparam logic [2:0] OP_SUB   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
  localparam logic [DW-1:0] DEPTH_TWO  = DW'(2);
  localparam logic [DW-1:0] DEPTH_ZERO = DW'(0);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_ISSUE      = 3'd2,
    S_ARITH_P1   = 3'd3,
    S_ARITH_P2   = 3'd4,
    S_ARITH_PUSH = 3'd5
  } state_t;

  state_t           state_r;
  logic [2:0]       stk_mode_r;
  logic [WIDTH-1:0] stk_d_r;
  logic [WIDTH-1:0] result_r;
  logic [DW-1:0]    depth_r;
  logic             err_ovf_r;
  logic             err_udf_r;
  logic             op_ready_r;

  logic             accept_s;
  logic             ovf_s;
  logic             udf_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;

  // Legality of the presented op against the current depth, plus the
  // arithmetic result that ADD/SUB latch at accept (carry/borrow dropped).
  always_comb begin
    accept_s = op_valid && op_ready_r;
    ovf_s    = 1'b0;
    udf_s    = 1'b0;
    sum_s    = stk_top1 + stk_top0;
    diff_s   = stk_top1 - stk_top0;
    case (op)
      OP_PUSH, OP_DUP: ovf_s = (depth_r >= DEPTH_FULL);
      OP_POP:          udf_s = (depth_r < DEPTH_ONE);
      OP_SWAP, OP_ADD, OP_SUB: udf_s = (depth_r < DEPTH_TWO);
      default: begin
        ovf_s = 1'b0;
        udf_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM: every output is registered so a command is presented for
  // exactly the cycle after the edge on which it was decided.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_INIT;
      stk_mode_r <= STACK_MODE_IDLE;
      stk_d_r    <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      depth_r    <= DEPTH_ZERO;
      err_ovf_r  <= 1'b0;
      err_udf_r  <= 1'b0;
      op_ready_r <= 1'b0;
    end else begin
      case (state_r)
        // Planes have no reset of their own: clear them through the same
        // one-cycle ISSUE slot that CLEAR uses.
        S_INIT: begin
          stk_mode_r <= STACK_MODE_RESET;
          depth_r    <= DEPTH_ZERO;
          op_ready_r <= 1'b0;
          state_r    <= S_ISSUE;
        end
        S_IDLE: begin
          stk_mode_r <= STACK_MODE_IDLE;
          if (accept_s) begin
            if (ovf_s) begin
              err_ovf_r <= 1'b1;
            end else if (udf_s) begin
              err_udf_r <= 1'b1;
            end else begin
              case (op)
                OP_PUSH: begin
                  stk_mode_r <= STACK_MODE_PUSH;
                  stk_d_r    <= op_data;
                  depth_r    <= depth_r + DEPTH_ONE;
                  op_ready_r <= 1'b0;
                  state_r    <= S_ISSUE;
                end
                OP_DUP: begin
                  stk_mode_r <= STACK_MODE_PUSH;
                  stk_d_r    <= stk_top0;
                  depth_r    <= depth_r + DEPTH_ONE;
                  op_ready_r <= 1'b0;
                  state_r    <= S_ISSUE;
                end
                OP_POP: begin
                  stk_mode_r <= STACK_MODE_POP;
                  depth_r    <= depth_r - DEPTH_ONE;
                  op_ready_r <= 1'b0;
                  state_r    <= S_ISSUE;
                end
                OP_SWAP: begin
                  stk_mode_r <= STACK_MODE_SWAP;
                  op_ready_r <= 1'b0;
                  state_r    <= S_ISSUE;
                end
                OP_CLEAR: begin
                  stk_mode_r <= STACK_MODE_RESET;
                  depth_r    <= DEPTH_ZERO;
                  err_ovf_r  <= 1'b0;
                  err_udf_r  <= 1'b0;
                  op_ready_r <= 1'b0;
                  state_r    <= S_ISSUE;
                end
                OP_ADD, OP_SUB: begin
                  // Depth follows each command: -1 here, -1 at P1, +1 at P2.
                  result_r   <= (op == OP_ADD) ? sum_s : diff_s;
                  stk_mode_r <= STACK_MODE_POP;
                  depth_r    <= depth_r - DEPTH_ONE;
                  op_ready_r <= 1'b0;
                  state_r    <= S_ARITH_P1;
                end
                default: begin
                  // NOP: consumed with no effect
                  state_r <= S_IDLE;
                end
              endcase
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          stk_mode_r <= STACK_MODE_IDLE;
          op_ready_r <= 1'b1;
          state_r    <= S_IDLE;
        end
        S_ARITH_P1: begin
          stk_mode_r <= STACK_MODE_POP;
          depth_r    <= depth_r - DEPTH_ONE;
          state_r    <= S_ARITH_P2;
        end
        S_ARITH_P2: begin
          stk_mode_r <= STACK_MODE_PUSH;
          stk_d_r    <= result_r;
          depth_r    <= depth_r + DEPTH_ONE;
          state_r    <= S_ARITH_PUSH;
        end
        S_ARITH_PUSH: begin
          stk_mode_r <= STACK_MODE_IDLE;
          op_ready_r <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          stk_mode_r <= STACK_MODE_IDLE;
          op_ready_r <= 1'b0;
          state_r    <= S_INIT;
        end
      endcase
    end
  end

  assign op_ready = op_ready_r;
  assign stk_mode = stk_mode_r;
  assign stk_d    = stk_d_r;
  assign depth    = depth_r;
  assign err_ovf  = err_ovf_r;
  assign err_udf  = err_udf_r;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: a behavioural word stack answers the
// sequencer's commands, directed ops push hand-computed expected commands
// into a queue, and a negedge monitor pops and compares every command.

module tb_stack_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int DW    = 4;

  localparam logic [2:0] M_IDLE  = 3'd0;
  localparam logic [2:0] M_PUSH  = 3'd1;
  localparam logic [2:0] M_POP   = 3'd2;
  localparam logic [2:0] M_SWAP  = 3'd3;
  localparam logic [2:0] M_RESET = 3'd4;

  localparam logic [2:0] O_NOP = 3'd0, O_PUSH = 3'd1, O_POP = 3'd2, O_SWAP = 3'd3;
  localparam logic [2:0] O_DUP = 3'd4, O_ADD = 3'd5, O_SUB = 3'd6, O_CLEAR = 3'd7;

  logic             clk;
  logic             rst;
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_data;
  logic             op_ready;
  logic [WIDTH-1:0] stk_top0;
  logic [WIDTH-1:0] stk_top1;
  logic [2:0]       stk_mode;
  logic [WIDTH-1:0] stk_d;
  logic [DW-1:0]    depth;
  logic             err_ovf;
  logic             err_udf;

  typedef struct packed {
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [WIDTH-1:0] mem [DEPTH];

  stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_data(op_data),
    .op_ready(op_ready), .stk_top0(stk_top0), .stk_top1(stk_top1),
    .stk_mode(stk_mode), .stk_d(stk_d), .depth(depth),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign stk_top0 = mem[0];
  assign stk_top1 = mem[1];

  // Behavioural bit-plane stack responding to the presented command
  always @(posedge clk) begin
    case (stk_mode)
      M_PUSH: begin
        for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
        mem[0] <= stk_d;
      end
      M_POP: begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
        mem[DEPTH-1] <= 8'h00;
      end
      M_SWAP: begin
        mem[0] <= mem[1];
        mem[1] <= mem[0];
      end
      M_RESET: begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end
      default: begin
      end
    endcase
  end

  // Monitor: every non-idle command must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && stk_mode != M_IDLE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got mode %0d data 0x%02h, expected no command", stk_mode, stk_d);
      end else begin
        e = exp_q.pop_front();
        if (stk_mode !== e.mode || (e.mode == M_PUSH && stk_d !== e.d)) begin
          errors++;
          $display("FAIL cmd: got mode %0d data 0x%02h, expected mode %0d data 0x%02h",
                   stk_mode, stk_d, e.mode, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic expect_cmd(input logic [2:0] m, input logic [WIDTH-1:0] d);
    exp_t e;
    e.mode = m;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (op_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (op_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: op_ready=%b expected 1", name, op_ready);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d);
    wait_ready("issue");
    op_valid = 1'b1;
    op       = o;
    op_data  = d;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op       = O_NOP;
    op_data  = 8'h00;
  endtask

  initial begin
    rst      = 1'b1;
    op_valid = 1'b0;
    op       = O_NOP;
    op_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_mode", 32'(stk_mode), 32'(M_IDLE));
    chk("rst_ready", 32'(op_ready), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_stk_d", 32'(stk_d), 32'd0);
    chk("rst_flags", 32'({err_ovf, err_udf}), 32'd0);
    expect_cmd(M_RESET, 8'h00);
    rst = 1'b0;
    wait_ready("init");
    chk("init_ready", 32'(op_ready), 32'd1);
    chk("init_depth", 32'(depth), 32'd0);
    chk("init_flags", 32'({err_ovf, err_udf}), 32'd0);

    // PUSH 5, PUSH 3, ADD -> 8
    expect_cmd(M_PUSH, 8'h05); do_op(O_PUSH, 8'h05);
    expect_cmd(M_PUSH, 8'h03); do_op(O_PUSH, 8'h03);
    wait_ready("p2");
    chk("depth_two", 32'(depth), 32'd2);
    expect_cmd(M_POP, 8'h00); expect_cmd(M_POP, 8'h00); expect_cmd(M_PUSH, 8'h08);
    do_op(O_ADD, 8'h00);
    wait_ready("add1");
    chk("add1_depth", 32'(depth), 32'd1);
    chk("add1_top", 32'(stk_top0), 32'h08);
    chk("add1_flags", 32'({err_ovf, err_udf}), 32'd0);

    // CLEAR keeps stk_d, zeroes depth
    expect_cmd(M_RESET, 8'h00); do_op(O_CLEAR, 8'h00);
    wait_ready("clr1");
    chk("clr1_depth", 32'(depth), 32'd0);
    chk("clr1_stk_d_hold", 32'(stk_d), 32'h08);

    // PUSH 3, PUSH 5, SUB -> 3-5 = 0xFE
    expect_cmd(M_PUSH, 8'h03); do_op(O_PUSH, 8'h03);
    expect_cmd(M_PUSH, 8'h05); do_op(O_PUSH, 8'h05);
    expect_cmd(M_POP, 8'h00); expect_cmd(M_POP, 8'h00); expect_cmd(M_PUSH, 8'hFE);
    do_op(O_SUB, 8'h00);
    wait_ready("sub");
    chk("sub_depth", 32'(depth), 32'd1);
    chk("sub_top", 32'(stk_top0), 32'hFE);

    // PUSH FF, PUSH 01, ADD -> 0x00 (carry dropped), below it 0xFE
    expect_cmd(M_PUSH, 8'hFF); do_op(O_PUSH, 8'hFF);
    expect_cmd(M_PUSH, 8'h01); do_op(O_PUSH, 8'h01);
    expect_cmd(M_POP, 8'h00); expect_cmd(M_POP, 8'h00); expect_cmd(M_PUSH, 8'h00);
    do_op(O_ADD, 8'h00);
    wait_ready("wrap");
    chk("wrap_depth", 32'(depth), 32'd2);
    chk("wrap_top0", 32'(stk_top0), 32'h00);
    chk("wrap_top1", 32'(stk_top1), 32'hFE);
    chk("wrap_flags", 32'({err_ovf, err_udf}), 32'd0);

    // Legal DUP copies top
    expect_cmd(M_RESET, 8'h00); do_op(O_CLEAR, 8'h00);
    expect_cmd(M_PUSH, 8'h42); do_op(O_PUSH, 8'h42);
    expect_cmd(M_PUSH, 8'h42); do_op(O_DUP, 8'h00);
    wait_ready("dup");
    chk("dup_depth", 32'(depth), 32'd2);
    chk("dup_top1", 32'(stk_top1), 32'h42);

    // Fill, then PUSH 0xAA refused
    expect_cmd(M_RESET, 8'h00); do_op(O_CLEAR, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      expect_cmd(M_PUSH, 8'(16 + i)); do_op(O_PUSH, 8'(16 + i));
    end
    wait_ready("fill");
    chk("full_depth", 32'(depth), 32'd8);
    do_op(O_PUSH, 8'hAA);
    chk("ovf_push_flag", 32'(err_ovf), 32'd1);
    chk("ovf_push_ready", 32'(op_ready), 32'd1);
    chk("ovf_push_depth", 32'(depth), 32'd8);

    // Fill again after CLEAR, then DUP refused
    expect_cmd(M_RESET, 8'h00); do_op(O_CLEAR, 8'h00);
    wait_ready("clr2");
    chk("clr2_flags", 32'({err_ovf, err_udf}), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      expect_cmd(M_PUSH, 8'(32 + i)); do_op(O_PUSH, 8'(32 + i));
    end
    do_op(O_DUP, 8'h00);
    chk("ovf_dup_flag", 32'(err_ovf), 32'd1);
    chk("ovf_dup_depth", 32'(depth), 32'd8);

    // Underflow cases
    expect_cmd(M_RESET, 8'h00); do_op(O_CLEAR, 8'h00);
    do_op(O_POP, 8'h00);
    chk("udf_pop_flag", 32'({err_ovf, err_udf}), 32'd1);
    chk("udf_pop_depth", 32'(depth), 32'd0);
    expect_cmd(M_RESET, 8'h00); do_op(O_CLEAR, 8'h00);
    expect_cmd(M_PUSH, 8'h07); do_op(O_PUSH, 8'h07);
    do_op(O_SWAP, 8'h00);
    chk("udf_swap_flag", 32'(err_udf), 32'd1);
    chk("udf_swap_depth", 32'(depth), 32'd1);
    expect_cmd(M_RESET, 8'h00); do_op(O_CLEAR, 8'h00);
    expect_cmd(M_PUSH, 8'h07); do_op(O_PUSH, 8'h07);
    do_op(O_ADD, 8'h00);
    chk("udf_add_flag", 32'(err_udf), 32'd1);
    chk("udf_add_depth", 32'(depth), 32'd1);
    expect_cmd(M_RESET, 8'h00); do_op(O_CLEAR, 8'h00);
    wait_ready("clr3");
    chk("clr3_flags", 32'({err_ovf, err_udf}), 32'd0);
    chk("clr3_depth", 32'(depth), 32'd0);

    // op_valid held through an ADD: next op waits for IDLE
    expect_cmd(M_PUSH, 8'h02); do_op(O_PUSH, 8'h02);
    expect_cmd(M_PUSH, 8'h04); do_op(O_PUSH, 8'h04);
    expect_cmd(M_POP, 8'h00); expect_cmd(M_POP, 8'h00); expect_cmd(M_PUSH, 8'h06);
    expect_cmd(M_PUSH, 8'h99);
    wait_ready("hold");
    op_valid = 1'b1; op = O_ADD;
    @(posedge clk); #1;
    op = O_PUSH; op_data = 8'h99;
    chk("hold_ready_p1", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold_ready_p2", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold_ready_push", 32'(op_ready), 32'd0);
    wait_ready("hold_idle");
    @(posedge clk); #1;
    op_valid = 1'b0; op = O_NOP; op_data = 8'h00;
    wait_ready("hold_done");
    chk("hold_depth", 32'(depth), 32'd2);
    chk("hold_top0", 32'(stk_top0), 32'h99);
    chk("hold_top1", 32'(stk_top1), 32'h06);

    // rst during ARITH_P2 aborts, then INIT clears the planes
    expect_cmd(M_POP, 8'h00);
    do_op(O_ADD, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_mode", 32'(stk_mode), 32'(M_IDLE));
    chk("abort_ready", 32'(op_ready), 32'd0);
    chk("abort_depth", 32'(depth), 32'd0);
    @(posedge clk); #1;
    expect_cmd(M_RESET, 8'h00);
    rst = 1'b0;
    wait_ready("abort_init");
    chk("abort_init_depth", 32'(depth), 32'd0);
    chk("abort_top0", 32'(stk_top0), 32'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
